// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: shared state encoding and pipeline-register bit positions for pipeline_ctrl.
package pipe_ctrl_pkg;
  typedef enum logic [1:0] {INIT, RUN, PEND} state_t;
  localparam int IDX_IF_ID  = 0;
  localparam int IDX_ID_EX  = 1;
  localparam int IDX_EX_MEM = 2;
  localparam int IDX_MEM_WB = 3;
  localparam logic [3:0] M_IF_ID  = 4'b1 << IDX_IF_ID;
  localparam logic [3:0] M_ID_EX  = 4'b1 << IDX_ID_EX;
  localparam logic [3:0] M_EX_MEM = 4'b1 << IDX_EX_MEM;
  localparam logic [3:0] M_MEM_WB = 4'b1 << IDX_MEM_WB;
endpackage

// File: rtl/hazard_detect.sv
// hazard_detect: combinational load-use comparator; register 0 is never a hazard.
module hazard_detect #(
  parameter int REG_ADDR_W = 5
) (
  input  logic [REG_ADDR_W-1:0] rs1_i,
  input  logic [REG_ADDR_W-1:0] rs2_i,
  input  logic                  use_rs1_i,
  input  logic                  use_rs2_i,
  input  logic [REG_ADDR_W-1:0] ex_rd_i,
  input  logic                  ex_is_load_i,
  output logic                  load_use_o
);
  assign load_use_o = ex_is_load_i && (ex_rd_i != '0) &&
                      ((use_rs1_i && rs1_i == ex_rd_i) || (use_rs2_i && rs2_i == ex_rd_i));
endmodule

// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: 5-stage pipeline sequencer (stall/flush/redirect priority, redirect held across dmem stalls).
// Optional perf counters enabled by defining PIPE_PERF_CNT_EN.
module pipeline_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int XLEN       = 64,
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 32
) (
  input  logic                  clk_i,
  input  logic                  rstn_i,
  input  logic [REG_ADDR_W-1:0] id_rs1_i,
  input  logic [REG_ADDR_W-1:0] id_rs2_i,
  input  logic                  id_use_rs1_i,
  input  logic                  id_use_rs2_i,
  input  logic [REG_ADDR_W-1:0] ex_rd_i,
  input  logic                  ex_is_load_i,
  input  logic                  ex_redirect_i,
  input  logic [XLEN-1:0]       ex_target_i,
  input  logic                  muldiv_busy_i,
  input  logic                  dmem_stall_i,
  output logic [3:0]            load_o,
  output logic [3:0]            flush_o,
  output logic                  pc_load_o,
  output logic                  pc_sel_o,
  output logic [XLEN-1:0]       pc_target_o,
  output logic [CNT_W-1:0]      stall_cycles_o,
  output logic [CNT_W-1:0]      redirects_o
);
  state_t state, nxt;
  logic [XLEN-1:0] pend_tgt;
  logic load_use, latch;
  hazard_detect #(.REG_ADDR_W(REG_ADDR_W)) u_hazard (
    .rs1_i(id_rs1_i),
    .rs2_i(id_rs2_i),
    .use_rs1_i(id_use_rs1_i),
    .use_rs2_i(id_use_rs2_i),
    .ex_rd_i(ex_rd_i),
    .ex_is_load_i(ex_is_load_i),
    .load_use_o(load_use)
  );
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state    <= INIT;
      pend_tgt <= '0;
    end else begin
      state <= nxt;
      if (latch) pend_tgt <= ex_target_i;
    end
  end
  // PEND replays the latched redirect as soon as memory releases, ignoring newer EX events
  always_comb begin
    nxt         = state;
    latch       = 1'b0;
    load_o      = '0;
    flush_o     = '0;
    pc_load_o   = 1'b0;
    pc_sel_o    = 1'b0;
    pc_target_o = '0;
    case (state)
      INIT: begin
        flush_o = M_IF_ID | M_ID_EX | M_EX_MEM | M_MEM_WB;
        nxt     = RUN;
      end
      RUN: begin
        pc_target_o = ex_target_i;
        if (dmem_stall_i) begin
          flush_o = M_MEM_WB;
          latch   = ex_redirect_i;
          nxt     = ex_redirect_i ? PEND : RUN;
        end else if (ex_redirect_i) begin
          load_o    = M_MEM_WB | M_EX_MEM;
          flush_o   = M_ID_EX | M_IF_ID;
          pc_load_o = 1'b1;
          pc_sel_o  = 1'b1;
        end else if (muldiv_busy_i) begin
          load_o  = M_MEM_WB;
          flush_o = M_EX_MEM;
        end else if (load_use) begin
          load_o  = M_MEM_WB | M_EX_MEM;
          flush_o = M_ID_EX;
        end else begin
          load_o    = M_MEM_WB | M_EX_MEM | M_ID_EX | M_IF_ID;
          pc_load_o = 1'b1;
        end
      end
      PEND: begin
        pc_target_o = pend_tgt;
        if (dmem_stall_i) begin
          flush_o = M_MEM_WB;
        end else begin
          load_o    = M_MEM_WB | M_EX_MEM;
          flush_o   = M_ID_EX | M_IF_ID;
          pc_load_o = 1'b1;
          pc_sel_o  = 1'b1;
          nxt       = RUN;
        end
      end
      default: nxt = INIT;
    endcase
  end
`ifdef PIPE_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt, redir_cnt;
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      stall_cnt <= '0;
      redir_cnt <= '0;
    end else begin
      if (state != INIT && !pc_load_o) stall_cnt <= stall_cnt + CNT_W'(1);
      if (pc_sel_o) redir_cnt <= redir_cnt + CNT_W'(1);
    end
  end
  assign stall_cycles_o = stall_cnt;
  assign redirects_o    = redir_cnt;
`else
  assign stall_cycles_o = '0;
  assign redirects_o    = '0;
`endif
endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb_pipeline_ctrl: vector table, corner sequences and random stimulus against a behavioural model.
module tb_pipeline_ctrl;
  typedef struct packed {
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        u1;
    logic        u2;
    logic [4:0]  rd;
    logic        ld;
    logic        redir;
    logic [63:0] tgt;
    logic        mul;
    logic        dmem;
  } in_t;
  typedef struct packed {
    in_t        i;
    logic [3:0] ld;
    logic [3:0] fl;
    logic       pl;
    logic       ps;
  } vec_t;

  logic clk, rstn;
  logic [4:0] id_rs1, id_rs2, ex_rd;
  logic id_use_rs1, id_use_rs2, ex_is_load, ex_redirect, muldiv_busy, dmem_stall;
  logic [63:0] ex_target, pc_target;
  logic [3:0] load, flush;
  logic pc_load, pc_sel;
  logic [31:0] stall_cycles, redirects;

  pipeline_ctrl dut (
    .clk_i(clk), .rstn_i(rstn),
    .id_rs1_i(id_rs1), .id_rs2_i(id_rs2),
    .id_use_rs1_i(id_use_rs1), .id_use_rs2_i(id_use_rs2),
    .ex_rd_i(ex_rd), .ex_is_load_i(ex_is_load),
    .ex_redirect_i(ex_redirect), .ex_target_i(ex_target),
    .muldiv_busy_i(muldiv_busy), .dmem_stall_i(dmem_stall),
    .load_o(load), .flush_o(flush), .pc_load_o(pc_load), .pc_sel_o(pc_sel),
    .pc_target_o(pc_target), .stall_cycles_o(stall_cycles), .redirects_o(redirects)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  bit m_init = 1'b1;
  bit m_pend = 1'b0;
  logic [63:0] m_tgt = '0;
  int unsigned m_stall = 0;
  int unsigned m_redir = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic in_t mk(input int rs1, input int rs2, input bit u1, input bit u2, input int rd,
                             input bit ld, input bit redir, input logic [63:0] tgt, input bit mul, input bit dmem);
    in_t x;
    x.rs1 = 5'(rs1); x.rs2 = 5'(rs2); x.u1 = u1; x.u2 = u2; x.rd = 5'(rd);
    x.ld = ld; x.redir = redir; x.tgt = tgt; x.mul = mul; x.dmem = dmem;
    return x;
  endfunction

  // Expected behaviour: a pending redirect overrides everything except a memory stall.
  task automatic model(input in_t x, input logic rn, output logic [3:0] ld, output logic [3:0] fl,
                       output logic pl, output logic ps, output logic [63:0] tg);
    bit red, mul, lu;
    ld = 4'b0000; fl = 4'b0000; pl = 1'b0; ps = 1'b0; tg = '0;
    if (!rn || m_init) begin
      fl = 4'b1111;
    end else begin
      red = m_pend || x.redir;
      mul = !m_pend && x.mul;
      lu  = !m_pend && x.ld && x.rd != 0 && ((x.u1 && x.rs1 == x.rd) || (x.u2 && x.rs2 == x.rd));
      tg  = m_pend ? m_tgt : x.tgt;
      if (x.dmem) fl = 4'b1000;
      else if (red) begin ld = 4'b1100; fl = 4'b0011; pl = 1'b1; ps = 1'b1; end
      else if (mul) begin ld = 4'b1000; fl = 4'b0100; end
      else if (lu) begin ld = 4'b1100; fl = 4'b0010; end
      else begin ld = 4'b1111; pl = 1'b1; end
    end
  endtask

  task automatic step(input in_t x, input logic rn);
    logic [3:0] e_ld, e_fl;
    logic e_pl, e_ps;
    logic [63:0] e_tg;
    @(negedge clk);
    id_rs1 = x.rs1; id_rs2 = x.rs2; id_use_rs1 = x.u1; id_use_rs2 = x.u2;
    ex_rd = x.rd; ex_is_load = x.ld; ex_redirect = x.redir; ex_target = x.tgt;
    muldiv_busy = x.mul; dmem_stall = x.dmem; rstn = rn;
    #1;
    model(x, rn, e_ld, e_fl, e_pl, e_ps, e_tg);
    chk("load", 64'(load), 64'(e_ld));
    chk("flush", 64'(flush), 64'(e_fl));
    chk("pc_load", 64'(pc_load), 64'(e_pl));
    chk("pc_sel", 64'(pc_sel), 64'(e_ps));
    chk("pc_target", pc_target, e_tg);
    chk("load_flush_overlap", 64'(load & flush), 64'd0);
`ifdef PIPE_PERF_CNT_EN
    chk("stall_cycles", 64'(stall_cycles), 64'(m_stall));
    chk("redirects", 64'(redirects), 64'(m_redir));
`else
    chk("stall_cycles", 64'(stall_cycles), 64'd0);
    chk("redirects", 64'(redirects), 64'd0);
`endif
    if (!rn) begin
      m_init = 1'b1; m_pend = 1'b0; m_tgt = '0; m_stall = 0; m_redir = 0;
    end else if (m_init) begin
      m_init = 1'b0;
    end else begin
      if (!e_pl) m_stall++;
      if (e_ps) m_redir++;
      if (m_pend) m_pend = x.dmem;
      else if (x.dmem && x.redir) begin m_pend = 1'b1; m_tgt = x.tgt; end
    end
  endtask

  vec_t vt[12];
  in_t idle, lu5, mlu;

  initial begin
    idle = mk(0, 0, 0, 0, 0, 0, 0, 64'd0, 0, 0);
    lu5  = mk(1, 5, 0, 1, 5, 1, 0, 64'd0, 0, 0);
    vt[0]  = '{mk(0, 0, 0, 0, 0, 0, 0, 64'd0, 0, 0),                4'b1111, 4'b0000, 1'b1, 1'b0};
    vt[1]  = '{mk(1, 5, 0, 1, 5, 1, 0, 64'd0, 0, 0),                4'b1100, 4'b0010, 1'b0, 1'b0};
    vt[2]  = '{mk(1, 0, 0, 1, 0, 1, 0, 64'd0, 0, 0),                4'b1111, 4'b0000, 1'b1, 1'b0};
    vt[3]  = '{mk(0, 0, 0, 0, 0, 0, 1, 64'h8000_0040, 0, 0),        4'b1100, 4'b0011, 1'b1, 1'b1};
    vt[4]  = '{mk(0, 0, 0, 0, 0, 0, 0, 64'h1234, 1, 0),             4'b1000, 4'b0100, 1'b0, 1'b0};
    vt[5]  = '{mk(7, 0, 1, 0, 7, 1, 0, 64'd0, 1, 0),                4'b1000, 4'b0100, 1'b0, 1'b0};
    vt[6]  = '{mk(7, 0, 1, 0, 7, 1, 1, 64'hdead_beef_0000_0010, 0, 0), 4'b1100, 4'b0011, 1'b1, 1'b1};
    vt[7]  = '{mk(0, 0, 0, 0, 0, 0, 0, 64'd0, 0, 1),                4'b0000, 4'b1000, 1'b0, 1'b0};
    vt[8]  = '{mk(3, 0, 1, 0, 3, 1, 0, 64'd0, 1, 1),                4'b0000, 4'b1000, 1'b0, 1'b0};
    vt[9]  = '{mk(9, 0, 0, 1, 9, 1, 0, 64'd0, 0, 0),                4'b1111, 4'b0000, 1'b1, 1'b0};
    vt[10] = '{mk(31, 0, 1, 0, 31, 1, 0, 64'd0, 0, 0),              4'b1100, 4'b0010, 1'b0, 1'b0};
    vt[11] = '{mk(4, 4, 1, 1, 4, 0, 0, 64'd0, 0, 0),                4'b1111, 4'b0000, 1'b1, 1'b0};

    // reset, then exactly one INIT cycle
    step(idle, 1'b0);
    step(idle, 1'b0);
    step(idle, 1'b1);
    chk("init_flush", 64'(flush), 64'hf);
    chk("init_load", 64'(load), 64'h0);
    chk("init_pc_load", 64'(pc_load), 64'd0);
    step(idle, 1'b1);
    chk("run_load", 64'(load), 64'hf);
    chk("run_pc_load", 64'(pc_load), 64'd1);

    for (int k = 0; k < 12; k++) begin
      step(vt[k].i, 1'b1);
      chk($sformatf("vec%0d_load", k), 64'(load), 64'(vt[k].ld));
      chk($sformatf("vec%0d_flush", k), 64'(flush), 64'(vt[k].fl));
      chk($sformatf("vec%0d_pc_load", k), 64'(pc_load), 64'(vt[k].pl));
      chk($sformatf("vec%0d_pc_sel", k), 64'(pc_sel), 64'(vt[k].ps));
      chk($sformatf("vec%0d_target", k), pc_target, vt[k].i.tgt);
    end

    // redirect behind a 3-cycle memory stall
    step(mk(0, 0, 0, 0, 0, 0, 1, 64'h100, 0, 1), 1'b1);
    step(mk(0, 0, 0, 0, 0, 0, 0, 64'h0, 0, 1), 1'b1);
    step(mk(0, 0, 0, 0, 0, 0, 1, 64'h999, 1, 1), 1'b1);
    chk("pend_stall_flush", 64'(flush), 64'h8);
    step(mk(2, 0, 1, 0, 2, 1, 0, 64'h777, 1, 0), 1'b1);
    chk("pend_apply_sel", 64'(pc_sel), 64'd1);
    chk("pend_apply_target", pc_target, 64'h100);
    step(idle, 1'b1);
    chk("after_pend_sel", 64'(pc_sel), 64'd0);

    // muldiv for 4 cycles with a pending load-use, then one bubble
    mlu = lu5; mlu.mul = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step(mlu, 1'b1);
      chk("muldiv_load", 64'(load), 64'h8);
    end
    step(lu5, 1'b1);
    chk("bubble_flush", 64'(flush), 64'h2);
    step(idle, 1'b1);

    // reset while a redirect is pending discards it
    step(mk(0, 0, 0, 0, 0, 0, 1, 64'h4000, 0, 1), 1'b1);
    step(mk(0, 0, 0, 0, 0, 0, 0, 64'h0, 0, 1), 1'b1);
    step(idle, 1'b0);
    chk("rst_pend_flush", 64'(flush), 64'hf);
    step(idle, 1'b1);
    step(idle, 1'b1);
    chk("rst_pend_no_redirect", 64'(pc_sel), 64'd0);
    chk("rst_pend_stall_cnt", 64'(stall_cycles), 64'd0);
    chk("rst_pend_redir_cnt", 64'(redirects), 64'd0);

    for (int k = 0; k < 2000; k++) begin
      in_t r;
      r = mk($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 1), $urandom_range(0, 1),
             $urandom_range(0, 3), $urandom_range(0, 1), $urandom_range(0, 5) == 0,
             {$urandom, $urandom}, $urandom_range(0, 4) == 0, $urandom_range(0, 3) == 0);
      step(r, $urandom_range(0, 149) != 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
